// File: rtl/sc_screen_sequencer_if.sv
// Game-logic / matrix_ctrl bus for the screen sequencer.
// master drives events, layers and address; slave returns column data and status.
interface sc_screen_sequencer_if #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 3
);
  logic                 SC_SCREENSEQ_levelStart_In;
  logic                 SC_SCREENSEQ_win_In;
  logic                 SC_SCREENSEQ_loss_In;
  logic [ROWS*COLS-1:0] SC_SCREENSEQ_point_InBUS;
  logic [ROWS*COLS-1:0] SC_SCREENSEQ_obstacle_InBUS;
  logic [ROWS*COLS-1:0] SC_SCREENSEQ_houses_InBUS;
  logic [ROWS*COLS-1:0] SC_SCREENSEQ_splash_InBUS;
  logic [ADDR_W-1:0]    SC_SCREENSEQ_addr_In;
  logic [ROWS-1:0]      SC_SCREENSEQ_data_OutBUS;
  logic [1:0]           SC_SCREENSEQ_splashSel_OutBUS;
  logic                 SC_SCREENSEQ_play_Out;
  logic                 SC_SCREENSEQ_levelDone_Out;

  modport master (
    output SC_SCREENSEQ_levelStart_In, SC_SCREENSEQ_win_In,
    output SC_SCREENSEQ_loss_In, SC_SCREENSEQ_point_InBUS,
    output SC_SCREENSEQ_obstacle_InBUS, SC_SCREENSEQ_houses_InBUS,
    output SC_SCREENSEQ_splash_InBUS, SC_SCREENSEQ_addr_In,
    input  SC_SCREENSEQ_data_OutBUS, SC_SCREENSEQ_splashSel_OutBUS,
    input  SC_SCREENSEQ_play_Out, SC_SCREENSEQ_levelDone_Out
  );

  modport slave (
    input  SC_SCREENSEQ_levelStart_In, SC_SCREENSEQ_win_In,
    input  SC_SCREENSEQ_loss_In, SC_SCREENSEQ_point_InBUS,
    input  SC_SCREENSEQ_obstacle_InBUS, SC_SCREENSEQ_houses_InBUS,
    input  SC_SCREENSEQ_splash_InBUS, SC_SCREENSEQ_addr_In,
    output SC_SCREENSEQ_data_OutBUS, SC_SCREENSEQ_splashSel_OutBUS,
    output SC_SCREENSEQ_play_Out, SC_SCREENSEQ_levelDone_Out
  );
endinterface

// File: rtl/sc_screen_sequencer.sv
// Screen sequencer: display FSM, layer compositing with point blink,
// and transposed registered column readout for the MAX7219 driver.
module sc_screen_sequencer #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int ADDR_W       = 3,
  parameter int TICK_W       = 26,
  parameter int SPLASH_TICKS = 50000000,
  parameter int BLINK_TICKS  = 12500000
) (
  input logic SC_SCREENSEQ_CLOCK_50,
  input logic SC_SCREENSEQ_RESET_InHigh,
  sc_screen_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEVEL, S_PLAY, S_WIN, S_LOSS
  } state_e;

  localparam logic [TICK_W-1:0] SPLASH_LAST = TICK_W'(SPLASH_TICKS - 1);
  localparam logic [TICK_W-1:0] BLINK_LAST  = TICK_W'(BLINK_TICKS - 1);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [ROWS-1:0]     data_q, data_d;
  logic [1:0]          sel_q, sel_d;
  logic                play_q, play_d;
  logic [ROWS*COLS-1:0] frame;

  logic start, win, loss;
  assign start = bus.SC_SCREENSEQ_levelStart_In;
  assign win   = bus.SC_SCREENSEQ_win_In;
  assign loss  = bus.SC_SCREENSEQ_loss_In;

  // Next state, splash/blink counter and blink phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEVEL;
          cnt_d   = '0;
        end
      end
      S_LEVEL: begin
        if (start) begin
          cnt_d = '0;
        end else if (cnt_q == SPLASH_LAST) begin
          state_d = S_PLAY;
          cnt_d   = '0;
          phase_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (loss) begin
          state_d = S_LOSS;
        end else if (win) begin
          state_d = S_WIN;
        end else if (start) begin
          state_d = S_LEVEL;
          cnt_d   = '0;
        end else if (BLINK_TICKS == 0) begin
          phase_d = 1'b1;
        end else if (cnt_q == BLINK_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WIN, S_LOSS: begin
        if (start) begin
          state_d = S_LEVEL;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status decodes follow the next state
  always_comb begin
    sel_d  = 2'd0;
    play_d = 1'b0;
    unique case (state_d)
      S_LEVEL: sel_d  = 2'd1;
      S_WIN:   sel_d  = 2'd2;
      S_LOSS:  sel_d  = 2'd3;
      S_PLAY:  play_d = 1'b1;
      default: sel_d  = 2'd0;
    endcase
  end

  // Compose the visible frame for the current state
  always_comb begin
    frame = '0;
    unique case (state_q)
      S_PLAY: frame = bus.SC_SCREENSEQ_obstacle_InBUS
                    | bus.SC_SCREENSEQ_houses_InBUS
                    | (bus.SC_SCREENSEQ_point_InBUS
                       & {(ROWS*COLS){phase_q}});
      S_LEVEL, S_WIN, S_LOSS:
        frame = bus.SC_SCREENSEQ_splash_InBUS;
      default: frame = '0;
    endcase
  end

  // Transpose: row 0 lands on the MSB, address 0 is the leftmost column
  always_comb begin
    data_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bus.SC_SCREENSEQ_addr_In == ADDR_W'(c))
          data_d[ROWS-1-r] = frame[r*COLS + COLS-1-c];
      end
    end
  end

  // State and output registers
  always_ff @(posedge SC_SCREENSEQ_CLOCK_50) begin
    if (SC_SCREENSEQ_RESET_InHigh) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      data_q  <= '0;
      sel_q   <= 2'd0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      play_q  <= play_d;
    end
  end

  assign bus.SC_SCREENSEQ_data_OutBUS      = data_q;
  assign bus.SC_SCREENSEQ_splashSel_OutBUS = sel_q;
  assign bus.SC_SCREENSEQ_play_Out         = play_q;
  assign bus.SC_SCREENSEQ_levelDone_Out    =
    (state_q == S_LEVEL) && (cnt_q == SPLASH_LAST) && !start;
endmodule
